// File: rtl/unidade_busca.sv
// Instruction-fetch stage for the 8-bit processor.
// Drives the instruction-memory address, captures the returned word into the
// instruction register (IR) and hands it to decode with a valid/ready handshake.
// Supports stall, taken-branch redirect with flush, address wrap-around and a
// HALT stop that is left only through Reset.
//
// Ports:
//   Clock       - single clock, rising edge
//   Reset       - synchronous, active-high
//   Instrucao   - word from instruction memory (one-cycle registered read)
//   Endereco    - address to instruction memory (combinational)
//   Pronto      - decode ready; transfer when Valido & Pronto at an edge
//   Desvio      - taken branch/jump pulse
//   AlvoDesvio  - branch target, sampled while Desvio=1
//   InstrucaoIR - registered instruction for decode
//   PCAtual     - address of InstrucaoIR
//   Valido      - InstrucaoIR holds an untransferred instruction
//   Parado      - high once a HALT word has been captured
module unidade_busca #(
  parameter int unsigned        LARGURA     = 8,
  parameter logic [LARGURA-1:0] OPCODE_HALT = LARGURA'(8'hFF)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] Instrucao,
  output logic [LARGURA-1:0] Endereco,
  input  logic               Pronto,
  input  logic               Desvio,
  input  logic [LARGURA-1:0] AlvoDesvio,
  output logic [LARGURA-1:0] InstrucaoIR,
  output logic [LARGURA-1:0] PCAtual,
  output logic               Valido,
  output logic               Parado
);

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_t;

  estado_t            estado;
  estado_t            estado_prox;
  logic [LARGURA-1:0] pc;        // next address to issue
  logic [LARGURA-1:0] end_pend;  // address whose word is on Instrucao now
  logic               pend;      // end_pend refers to a live fetch
  logic               captura;

  // IR can take the pending word: it is empty or being drained, and no branch
  assign captura = (estado == BUSCA) & pend & (~Valido | Pronto) & ~Desvio;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= INICIO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next-state logic
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIO: estado_prox = BUSCA;
      BUSCA: begin
        if (captura && (Instrucao == OPCODE_HALT)) begin
          estado_prox = PARADO;
        end
      end
      PARADO:  estado_prox = PARADO;
      default: estado_prox = INICIO;
    endcase
  end

  // Output logic: memory address selection and halt flag
  always_comb begin
    Endereco = end_pend;
    Parado   = 1'b0;
    case (estado)
      INICIO: Endereco = pc;
      BUSCA: begin
        if (Desvio) begin
          Endereco = AlvoDesvio;
        end else if (captura) begin
          Endereco = pc;
        end else begin
          // stall: re-request the pending word so it is presented again
          Endereco = end_pend;
        end
      end
      PARADO:  Parado = 1'b1;
      default: Endereco = end_pend;
    endcase
  end

  // Fetch datapath: PC, pending address, IR and handshake
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc          <= '0;
      end_pend    <= '0;
      pend        <= 1'b0;
      InstrucaoIR <= '0;
      PCAtual     <= '0;
      Valido      <= 1'b0;
    end else begin
      case (estado)
        INICIO: begin
          end_pend <= pc;
          pc       <= pc + LARGURA'(1);
          pend     <= 1'b1;
        end
        BUSCA: begin
          if (Desvio) begin
            // flush IR and drop the in-flight word; fetch target directly
            Valido   <= 1'b0;
            end_pend <= AlvoDesvio;
            pc       <= AlvoDesvio + LARGURA'(1);
            pend     <= 1'b1;
          end else if (captura) begin
            InstrucaoIR <= Instrucao;
            PCAtual     <= end_pend;
            Valido      <= 1'b1;
            end_pend    <= pc;
            pc          <= pc + LARGURA'(1);
          end
        end
        PARADO: begin
          // only the final HALT transfer remains
          if (Pronto) begin
            Valido <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Testbench for unidade_busca: instruction memory model, transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_unidade_busca;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instrucao;
  logic [7:0] endereco;
  logic       pronto;
  logic       desvio;
  logic [7:0] alvo;
  logic [7:0] ir;
  logic [7:0] pc_atual;
  logic       valido;
  logic       parado;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  unidade_busca #(.LARGURA(8), .OPCODE_HALT(8'hFF)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Instrucao  (instrucao),
    .Endereco   (endereco),
    .Pronto     (pronto),
    .Desvio     (desvio),
    .AlvoDesvio (alvo),
    .InstrucaoIR(ir),
    .PCAtual    (pc_atual),
    .Valido     (valido),
    .Parado     (parado)
  );

  always #5 clk = ~clk;

  // instruction memory with one-cycle registered read
  always @(posedge clk) instrucao <= mem[endereco];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: what decode should see, in terms of the instruction stream
  bit         m_ok = 1'b0;
  bit         m_valid;
  bit         m_halted;
  logic [7:0] m_ir;
  logic [7:0] m_pc;
  logic [7:0] m_next;   // address of the next instruction to be delivered
  int         m_lat;    // edges left before the first delivery after reset

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_valid = 1'b0; m_halted = 1'b0;
      m_ir = 8'h00; m_pc = 8'h00; m_next = 8'h00; m_lat = 1;
    end else if (m_ok) begin
      if (m_halted) begin
        if (m_valid && pronto) m_valid = 1'b0;
      end else if (m_lat > 0) begin
        m_lat--;
      end else if (desvio) begin
        m_valid = 1'b0;
        m_next  = alvo;
      end else if (!m_valid || pronto) begin
        m_ir    = mem[m_next];
        m_pc    = m_next;
        m_valid = 1'b1;
        m_next  = m_next + 8'd1;
        if (m_ir == 8'hFF) m_halted = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [7:0] e;
    if (m_ok) begin
      check("model_valido", {7'd0, valido}, {7'd0, m_valid});
      check("model_parado", {7'd0, parado}, {7'd0, m_halted});
      check("model_ir", ir, m_ir);
      check("model_pcatual", pc_atual, m_pc);
      if (!rst) begin
        if (m_halted || m_lat > 0) e = m_next;
        else if (desvio)           e = alvo;
        else if (!m_valid || pronto) e = m_next + 8'd1;
        else                       e = m_next;
        check("model_endereco", endereco, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ir(input string name, input logic [7:0] e_ir, input logic [7:0] e_pc);
    check({name, "_valido"}, {7'd0, valido}, 8'd1);
    check({name, "_ir"}, ir, e_ir);
    check({name, "_pc"}, pc_atual, e_pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    rst = 1'b1; pronto = 1'b1; desvio = 1'b0; alvo = 8'h00;
    step(); step();
    check("rst_valido", {7'd0, valido}, 8'd0);
    check("rst_ir", ir, 8'h00);
    check("rst_parado", {7'd0, parado}, 8'd0);

    // reset release, streaming with Pronto=1
    rst = 1'b0; #1;
    check("inicio_end", endereco, 8'h00);
    step();
    check("lat1_valido", {7'd0, valido}, 8'd0);
    check("lat1_end", endereco, 8'h01);
    step(); expect_ir("first", 8'h10, 8'h00);
    step(); expect_ir("seq1", 8'h11, 8'h01);
    step(); expect_ir("seq2", 8'h12, 8'h02);
    step(); expect_ir("seq3", 8'h13, 8'h03);

    // stall 3 cycles
    pronto = 1'b0; #1;
    check("stall_end", endereco, 8'h04);
    for (int i = 0; i < 3; i++) begin
      step(); expect_ir("stall", 8'h13, 8'h03);
    end
    pronto = 1'b1;
    step(); expect_ir("resume1", 8'h14, 8'h04);
    step(); expect_ir("resume2", 8'h15, 8'h05);

    // branch to 0x40 while a transfer is also happening
    desvio = 1'b1; alvo = 8'h40; #1;
    check("br_end", endereco, 8'h40);
    step(); desvio = 1'b0;
    check("br_flush", {7'd0, valido}, 8'd0);
    step(); expect_ir("br_t1", 8'h50, 8'h40);
    step(); expect_ir("br_t2", 8'h51, 8'h41);

    // branch to 0xFE and wrap
    desvio = 1'b1; alvo = 8'hFE;
    step(); desvio = 1'b0;
    check("wrap_flush", {7'd0, valido}, 8'd0);
    step(); expect_ir("wrap_fe", 8'h0E, 8'hFE);
    step(); expect_ir("wrap_ff", 8'h0F, 8'hFF);
    step(); expect_ir("wrap_00", 8'h10, 8'h00);

    // HALT at address 5
    rst = 1'b1; mem[5] = 8'hFF;
    step(); rst = 1'b0;
    check("rst2_valido", {7'd0, valido}, 8'd0);
    repeat (6) step();
    expect_ir("pre_halt", 8'h14, 8'h04);
    step(); pronto = 1'b0;
    expect_ir("halt", 8'hFF, 8'h05);
    check("halt_parado", {7'd0, parado}, 8'd1);
    step(); expect_ir("halt_hold", 8'hFF, 8'h05);
    desvio = 1'b1; alvo = 8'h40;
    step(); desvio = 1'b0;
    expect_ir("halt_desvio", 8'hFF, 8'h05);
    pronto = 1'b1;
    step();
    check("halt_xfer", {7'd0, valido}, 8'd0);
    desvio = 1'b1;
    step(); desvio = 1'b0;
    step();
    check("halt_stays", {7'd0, valido}, 8'd0);
    check("halt_parado2", {7'd0, parado}, 8'd1);
    rst = 1'b1; mem[5] = 8'h15;
    step(); rst = 1'b0;
    check("halt_rst_parado", {7'd0, parado}, 8'd0);
    step(); step(); expect_ir("restart", 8'h10, 8'h00);

    // reset during stall
    step(); step(); expect_ir("pre_stall", 8'h12, 8'h02);
    pronto = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check("rst_stall_valido", {7'd0, valido}, 8'd0);
    check("rst_stall_ir", ir, 8'h00);
    check("rst_stall_pc", pc_atual, 8'h00);

    // reset during branch
    rst = 1'b0; pronto = 1'b1;
    step(); step(); step(); expect_ir("pre_br", 8'h11, 8'h01);
    desvio = 1'b1; alvo = 8'h80; rst = 1'b1;
    step(); rst = 1'b0; desvio = 1'b0;
    check("rst_br_ir", ir, 8'h00);
    check("rst_br_pc", pc_atual, 8'h00);
    #1 check("rst_br_end", endereco, 8'h00);
    step();
    check("rst_br_lat", {7'd0, valido}, 8'd0);
    step(); expect_ir("rst_br_first", 8'h10, 8'h00);
    step(); expect_ir("rst_br_second", 8'h11, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
